// File: rtl/fetch_if.sv
// Fetch-unit bus: PC handshake, memory read port and decode handshake.
// master = fetch unit, slave = PC/memory/decode side.
interface fetch_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic [15:0]       pc_addr;
  logic              pc_inc;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] imm;
  logic              ir_long;
  logic              ir_valid;
  logic              ir_ack;
  logic              flush;
  logic              busy;

  modport master (
    input  pc_addr, mem_ready, mem_rdata, ir_ack, flush,
    output pc_inc, mem_req, mem_addr, ir, imm, ir_long, ir_valid, busy
  );

  modport slave (
    output pc_addr, mem_ready, mem_rdata, ir_ack, flush,
    input  pc_inc, mem_req, mem_addr, ir, imm, ir_long, ir_valid, busy
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads one or two words at the PC, pulses pc_inc
// per captured word and presents the instruction to decode under valid/ack.
//
// state | meaning
// REQ1  | issue read of the first (instruction) word
// WAIT1 | waiting for the first word
// REQ2  | gap cycle while the PC advances, then read the immediate word
// WAIT2 | waiting for the immediate word
// HOLD  | instruction valid, waiting for decode ack
// DRAIN | flushed while a read was outstanding; swallow its completion
module fetch_unit #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 12,
  parameter int LONG_BIT = 15
) (
  input logic    clk,
  input logic    reset,
  fetch_if.master bus
);
  typedef enum logic [2:0] {REQ1, WAIT1, REQ2, WAIT2, HOLD, DRAIN} state_t;

  state_t            state, state_nxt;
  logic              mem_req_q, mem_req_nxt;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
  logic              pc_inc_q, pc_inc_nxt;
  logic [DATA_W-1:0] ir_q, ir_nxt;
  logic [DATA_W-1:0] imm_q, imm_nxt;
  logic              long_q, long_nxt;
  logic              valid_q, valid_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= REQ1;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      pc_inc_q   <= 1'b0;
      ir_q       <= '0;
      imm_q      <= '0;
      long_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      mem_req_q  <= mem_req_nxt;
      mem_addr_q <= mem_addr_nxt;
      pc_inc_q   <= pc_inc_nxt;
      ir_q       <= ir_nxt;
      imm_q      <= imm_nxt;
      long_q     <= long_nxt;
      valid_q    <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    mem_req_nxt  = mem_req_q;
    mem_addr_nxt = mem_addr_q;
    pc_inc_nxt   = 1'b0;
    ir_nxt       = ir_q;
    imm_nxt      = imm_q;
    long_nxt     = long_q;
    valid_nxt    = valid_q;
    case (state)
      REQ1: begin
        if (bus.flush) begin
          valid_nxt = 1'b0;
          long_nxt  = 1'b0;
        end else begin
          mem_req_nxt  = 1'b1;
          mem_addr_nxt = bus.pc_addr[ADDR_W-1:0];
          state_nxt    = WAIT1;
        end
      end
      WAIT1, WAIT2: begin
        if (bus.flush) begin
          valid_nxt = 1'b0;
          long_nxt  = 1'b0;
          if (bus.mem_ready) begin
            mem_req_nxt = 1'b0;
            state_nxt   = REQ1;
          end else begin
            state_nxt = DRAIN;
          end
        end else if (bus.mem_ready) begin
          mem_req_nxt = 1'b0;
          pc_inc_nxt  = 1'b1;
          if (state == WAIT1) begin
            ir_nxt = bus.mem_rdata;
            if (bus.mem_rdata[LONG_BIT]) begin
              long_nxt  = 1'b1;
              state_nxt = REQ2;
            end else begin
              imm_nxt   = '0;
              long_nxt  = 1'b0;
              valid_nxt = 1'b1;
              state_nxt = HOLD;
            end
          end else begin
            imm_nxt   = bus.mem_rdata;
            valid_nxt = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      REQ2: begin
        if (bus.flush) begin
          valid_nxt = 1'b0;
          long_nxt  = 1'b0;
          state_nxt = REQ1;
        end else begin
          mem_req_nxt  = 1'b1;
          mem_addr_nxt = bus.pc_addr[ADDR_W-1:0];
          state_nxt    = WAIT2;
        end
      end
      HOLD: begin
        if (bus.flush) begin
          valid_nxt = 1'b0;
          long_nxt  = 1'b0;
          state_nxt = REQ1;
        end else if (bus.ir_ack) begin
          valid_nxt = 1'b0;
          state_nxt = REQ1;
        end
      end
      DRAIN: begin
        // completion of the abandoned read is dropped without a pc_inc
        if (bus.mem_ready) begin
          mem_req_nxt = 1'b0;
          state_nxt   = REQ1;
        end
      end
      default: state_nxt = REQ1;
    endcase
  end

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.pc_inc   = pc_inc_q;
  assign bus.ir       = ir_q;
  assign bus.imm      = imm_q;
  assign bus.ir_long  = long_q;
  assign bus.ir_valid = valid_q;
  assign bus.busy     = (state != HOLD);
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a PC model (falling-edge update, load
// priority) and a latency-programmable memory responder.
module tb_fetch_unit;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  fetch_if #(.DATA_W(16), .ADDR_W(12)) bus ();

  fetch_unit #(.DATA_W(16), .ADDR_W(12), .LONG_BIT(15)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:4095];
  logic [15:0] pc = '0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_val = '0;
  logic        ack = 1'b0;
  logic        flush = 1'b0;
  logic        auto_rdy = 1'b1;
  logic        force_rdy = 1'b0;
  int          lat = 0;
  int          cnt;
  int          inc_cnt = 0;

  always @(negedge clk) begin
    if (pc_load) pc <= pc_val;
    else if (bus.pc_inc === 1'b1) pc <= pc + 16'd1;
    if (bus.pc_inc === 1'b1) inc_cnt <= inc_cnt + 1;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) cnt <= 0;
    else if (!bus.mem_req || bus.mem_ready) cnt <= 0;
    else cnt <= cnt + 1;
  end

  assign bus.pc_addr   = pc;
  assign bus.mem_ready = bus.mem_req && (force_rdy || (auto_rdy && (cnt == lat)));
  assign bus.mem_rdata = mem[bus.mem_addr];
  assign bus.ir_ack    = ack;
  assign bus.flush     = flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h000] = 16'h1234;
    mem[12'h001] = 16'h0021;
    mem[12'h010] = 16'h8005;
    mem[12'h011] = 16'hBEEF;
    mem[12'h012] = 16'h7777;
    mem[12'h100] = 16'h0042;
    mem[12'h200] = 16'h9ABC;
    mem[12'h201] = 16'h0055;
    mem[12'h202] = 16'h8001;
    mem[12'h203] = 16'h1111;
    mem[12'h204] = 16'h0007;

    // reset state
    reset = 1'b1;
    #12;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_pc_inc", bus.pc_inc, 0);
    chk("rst_ir", bus.ir, 0);
    chk("rst_imm", bus.imm, 0);
    chk("rst_ir_long", bus.ir_long, 0);
    chk("rst_ir_valid", bus.ir_valid, 0);
    chk("rst_busy", bus.busy, 1);
    @(posedge clk);
    #1 reset = 1'b0;

    // 1: zero-wait one-word fetch, ack tied high
    ack = 1'b1;
    lat = 0;
    step();
    chk("t1_req", bus.mem_req, 1);
    chk("t1_addr", bus.mem_addr, 12'h000);
    step();
    chk("t1_ir", bus.ir, 16'h1234);
    chk("t1_long", bus.ir_long, 0);
    chk("t1_imm", bus.imm, 0);
    chk("t1_valid", bus.ir_valid, 1);
    chk("t1_pc_inc", bus.pc_inc, 1);
    chk("t1_req_drop", bus.mem_req, 0);
    chk("t1_busy_hold", bus.busy, 0);
    step();
    chk("t1_pc_inc_pulse", bus.pc_inc, 0);
    chk("t1_valid_clr", bus.ir_valid, 0);
    chk("t1_inc_cnt", inc_cnt, 1);
    step();
    chk("t1_next_req", bus.mem_req, 1);
    chk("t1_next_addr", bus.mem_addr, 12'h001);
    ack = 1'b0;
    step();
    chk("t1b_ir", bus.ir, 16'h0021);
    chk("t1b_valid", bus.ir_valid, 1);

    // flush in HOLD with PC reload to 0x010
    flush = 1'b1; pc_load = 1'b1; pc_val = 16'h0010; lat = 2;
    step();
    flush = 1'b0; pc_load = 1'b0;
    chk("hold_flush_valid", bus.ir_valid, 0);
    chk("hold_flush_busy", bus.busy, 1);
    chk("hold_flush_req", bus.mem_req, 0);

    // 2: two-word instruction, ready delayed 2 cycles per word
    step();
    chk("t2_addr1", bus.mem_addr, 12'h010);
    chk("t2_req1", bus.mem_req, 1);
    step();
    chk("t2_addr1_held", bus.mem_addr, 12'h010);
    chk("t2_no_inc_wait", bus.pc_inc, 0);
    step();
    chk("t2_addr1_held2", bus.mem_addr, 12'h010);
    chk("t2_req1_held", bus.mem_req, 1);
    step();
    chk("t2_ir", bus.ir, 16'h8005);
    chk("t2_long", bus.ir_long, 1);
    chk("t2_valid_early", bus.ir_valid, 0);
    chk("t2_inc1", bus.pc_inc, 1);
    chk("t2_req_gap", bus.mem_req, 0);
    step();
    chk("t2_addr2", bus.mem_addr, 12'h011);
    chk("t2_req2", bus.mem_req, 1);
    chk("t2_inc_pulse", bus.pc_inc, 0);
    step();
    step();
    chk("t2_addr2_held", bus.mem_addr, 12'h011);
    step();
    chk("t2_imm", bus.imm, 16'hBEEF);
    chk("t2_ir_keep", bus.ir, 16'h8005);
    chk("t2_long_keep", bus.ir_long, 1);
    chk("t2_valid", bus.ir_valid, 1);
    chk("t2_inc2", bus.pc_inc, 1);

    // 3: ack withheld for 5 cycles in HOLD
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_valid", bus.ir_valid, 1);
      chk("t3_ir", bus.ir, 16'h8005);
      chk("t3_no_req", bus.mem_req, 0);
      chk("t3_busy", bus.busy, 0);
    end
    chk("t3_inc_cnt", inc_cnt, 4);
    ack = 1'b1;
    step();
    ack = 1'b0;
    auto_rdy = 1'b0;
    chk("t3_ack_valid", bus.ir_valid, 0);
    chk("t3_ack_busy", bus.busy, 1);
    step();
    chk("t3_restart_req", bus.mem_req, 1);
    chk("t3_restart_addr", bus.mem_addr, 12'h012);

    // 4: flush in WAIT1, ready 3 cycles later, PC reloaded to 0x100
    flush = 1'b1; pc_load = 1'b1; pc_val = 16'h0100;
    step();
    flush = 1'b0; pc_load = 1'b0;
    chk("t4_drain_req", bus.mem_req, 1);
    chk("t4_drain_addr", bus.mem_addr, 12'h012);
    chk("t4_drain_busy", bus.busy, 1);
    step();
    chk("t4_drain_req2", bus.mem_req, 1);
    force_rdy = 1'b1;
    step();
    force_rdy = 1'b0; auto_rdy = 1'b1; lat = 0;
    chk("t4_req_drop", bus.mem_req, 0);
    chk("t4_no_inc", bus.pc_inc, 0);
    chk("t4_valid", bus.ir_valid, 0);
    chk("t4_ir_kept", bus.ir, 16'h8005);
    step();
    chk("t4_new_addr", bus.mem_addr, 12'h100);
    chk("t4_inc_cnt", inc_cnt, 4);

    // 5: flush together with mem_ready and ir_ack
    flush = 1'b1; ack = 1'b1; pc_load = 1'b1; pc_val = 16'h0200;
    step();
    flush = 1'b0; ack = 1'b0; pc_load = 1'b0;
    chk("t5_valid", bus.ir_valid, 0);
    chk("t5_no_inc", bus.pc_inc, 0);
    chk("t5_ir_kept", bus.ir, 16'h8005);
    chk("t5_req_drop", bus.mem_req, 0);
    step();
    chk("t5_addr", bus.mem_addr, 12'h200);
    chk("t5_inc_cnt", inc_cnt, 4);
    step();
    chk("t5_ir_long", bus.ir, 16'h9ABC);
    chk("t5_long", bus.ir_long, 1);
    lat = 3;
    step();
    chk("t6_wait2_addr", bus.mem_addr, 12'h201);

    // 6: reset in WAIT2
    #2 reset = 1'b1;
    #1;
    chk("t6_req_async", bus.mem_req, 0);
    chk("t6_addr", bus.mem_addr, 0);
    chk("t6_ir", bus.ir, 0);
    chk("t6_long", bus.ir_long, 0);
    chk("t6_valid", bus.ir_valid, 0);
    chk("t6_pc_inc", bus.pc_inc, 0);
    lat = 0;
    step();
    reset = 1'b0;
    chk("t6_valid_after", bus.ir_valid, 0);
    step();
    chk("t6_resume_req", bus.mem_req, 1);
    chk("t6_resume_addr", bus.mem_addr, 12'h201);
    step();
    chk("t6_ir_new", bus.ir, 16'h0055);
    chk("t6_imm_zero", bus.imm, 0);
    chk("t6_valid_new", bus.ir_valid, 1);

    // back-to-back two-word then one-word with ack tied high
    ack = 1'b1;
    step();
    step();
    chk("bb_addr1", bus.mem_addr, 12'h202);
    step();
    chk("bb_ir", bus.ir, 16'h8001);
    step();
    chk("bb_addr2", bus.mem_addr, 12'h203);
    step();
    chk("bb_imm", bus.imm, 16'h1111);
    chk("bb_valid", bus.ir_valid, 1);
    step();
    chk("bb_req1_again", bus.busy, 1);
    step();
    chk("bb_addr3", bus.mem_addr, 12'h204);
    step();
    chk("bb_short_ir", bus.ir, 16'h0007);
    chk("bb_short_imm", bus.imm, 0);
    chk("bb_short_long", bus.ir_long, 0);
    step();
    chk("bb_inc_cnt", inc_cnt, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
